// File: rtl/ahb5_tb_pkg.sv
// ahb5_tb_pkg: shared AHB5/APB4 constants, scoreboard entry type and helpers
package ahb5_tb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  typedef enum logic [2:0] {HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2} hsize_e;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ADDR = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_STALL = 3'd3;
  localparam state_t S_DRAIN = 3'd4;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    hsize_e      size;
  } sb_entry_t;
  function automatic logic [3:0] exp_strb(input logic write, input hsize_e size, input logic [1:0] a);
    return !write ? 4'b0000 : size == HSIZE_BYTE ? 4'b0001 << a : size == HSIZE_HALF ? 4'b0011 << a : 4'b1111;
  endfunction
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? (v >> 1) ^ LFSR_POLY : v >> 1;
  endfunction
  function automatic logic [31:0] bitrev(input logic [31:0] v);
    for (int i = 0; i < 32; i++) bitrev[i] = v[31-i];
  endfunction
endpackage

// File: rtl/ahb5_rand_txn_gen_chk_sb_fifo.sv
// sb_fifo: synchronous scoreboard FIFO; simultaneous push and pop allowed even when full
module sb_fifo
  import ahb5_tb_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = sb_entry_t
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         din_i,
  output T                         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign rd = pop_i && !empty_o;
  assign wr = push_i && (!full_o || rd);
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rp_q];
  // pointers and occupancy, flushed by reset
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  // entry storage; contents behind the pointers are don't-care
  always_ff @(posedge HCLK)
    if (wr) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/ahb5_rand_txn_gen_chk.sv
// ahb5_rand_txn_gen_chk: random AHB5 single-transfer master with in-order APB4 scoreboard
module ahb5_rand_txn_gen_chk
  import ahb5_tb_pkg::*;
#(
  parameter int          NUM_AHB   = 2,
  parameter int          SB_DEPTH  = 8,
  parameter int          NUM_TXN   = 256,
  parameter logic [31:0] ADDR_BASE = 32'h4000_0000,
  parameter logic [31:0] ADDR_MASK = 32'h0000_0FFF,
  parameter logic [31:0] SEED      = 32'hACE1_2024
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      start,
  output logic [NUM_AHB-1:0][31:0]  HADDR,
  output logic [NUM_AHB-1:0][31:0]  HWDATA,
  output logic [NUM_AHB-1:0]        HWRITE,
  output logic [NUM_AHB-1:0]        HSEL,
  output logic [NUM_AHB-1:0]        HMASTLOCK,
  output logic [NUM_AHB-1:0]        HNONSEC,
  output logic [NUM_AHB-1:0][2:0]   HSIZE,
  output logic [NUM_AHB-1:0][2:0]   HBURST,
  output logic [NUM_AHB-1:0][3:0]   HPROT,
  output logic [NUM_AHB-1:0][3:0]   HCID,
  output logic [NUM_AHB-1:0][1:0]   HTRANS,
  input  logic [NUM_AHB-1:0]        HREADY,
  input  logic [NUM_AHB-1:0]        HRESP,
  input  logic [NUM_AHB-1:0][31:0]  HRDATA,
  input  logic [31:0]               PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [3:0]                PSTRB,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               mismatch_cnt,
  output logic [15:0]               ahb_err_cnt,
  output logic [15:0]               apb_err_cnt
);
  localparam int CW = NUM_AHB > 1 ? $clog2(NUM_AHB) : 1;
  state_t state_q, state_d;
  logic [31:0] lfsr_q, issued_q, wdata_q, raw;
  logic [CW-1:0] ch_q, ch_nxt;
  logic done_q, hready_a, push, pop, full, empty, apb_fire, bad, act;
  logic [15:0] mis_q, aerr_q, perr_q;
  logic [$clog2(SB_DEPTH):0] sb_count_unused;
  logic unused_ok;
  hsize_e sz;
  sb_entry_t ent, head;
  assign sz = hsize_e'(lfsr_q[1:0] == 2'b11 ? 3'd2 : {1'b0, lfsr_q[1:0]});
  assign raw = ADDR_BASE | (lfsr_q & ADDR_MASK);
  assign ent = '{addr: sz == HSIZE_WORD ? {raw[31:2], 2'b00} : sz == HSIZE_HALF ? {raw[31:1], 1'b0} : raw,
                 wdata: bitrev(lfsr_q), write: lfsr_q[2], size: sz};
  assign hready_a = HREADY[ch_q];
  assign ch_nxt = ch_q == CW'(NUM_AHB - 1) ? '0 : ch_q + 1'b1;
  assign act = state_q == S_ADDR;
  assign push = act && hready_a;
  assign apb_fire = PSEL && PENABLE && PREADY;
  assign pop = apb_fire && !empty;
  assign bad = empty || PADDR != head.addr || PWRITE != head.write || (head.write && PWDATA != head.wdata) ||
               PSTRB != exp_strb(head.write, head.size, head.addr[1:0]);
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign mismatch_cnt = mis_q;
  assign ahb_err_cnt = aerr_q;
  assign apb_err_cnt = perr_q;
  assign HBURST = {NUM_AHB{HBURST_SINGLE}};
  assign HMASTLOCK = '0;
  assign unused_ok = ^{HRDATA, sb_count_unused};
  sb_fifo #(.DEPTH(SB_DEPTH), .T(sb_entry_t)) u_fifo (
    .HCLK(HCLK), .HRESETn(HRESETn), .push_i(push), .pop_i(pop), .din_i(ent),
    .dout_o(head), .full_o(full), .empty_o(empty), .count_o(sb_count_unused)
  );
  // run sequencing: one address phase then one data phase per transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_ADDR : S_IDLE;
      S_ADDR:  state_d = hready_a ? S_DATA : S_ADDR;
      S_DATA:  state_d = !hready_a ? S_DATA : issued_q == NUM_TXN ? S_DRAIN : full ? S_STALL : S_ADDR;
      S_STALL: state_d = full ? S_STALL : S_ADDR;
      S_DRAIN: state_d = empty ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  // only the active channel is driven; address/control in ADDR, write data in DATA
  always_comb begin
    HADDR = '0;
    HWDATA = '0;
    HWRITE = '0;
    HSEL = '0;
    HNONSEC = '0;
    HSIZE = '0;
    HPROT = '0;
    HCID = '0;
    HTRANS = '0;
    for (int i = 0; i < NUM_AHB; i++)
      if (CW'(i) == ch_q) begin
        HSEL[i] = act;
        HTRANS[i] = act ? HTRANS_NONSEQ : HTRANS_IDLE;
        HADDR[i] = act ? ent.addr : '0;
        HWRITE[i] = act && ent.write;
        HSIZE[i] = act ? ent.size : 3'd0;
        HPROT[i] = act ? lfsr_q[6:3] : 4'd0;
        HCID[i] = act ? lfsr_q[10:7] : 4'd0;
        HNONSEC[i] = act && lfsr_q[11];
        HWDATA[i] = state_q == S_DATA ? wdata_q : '0;
      end
  end
  // generator state: LFSR steps only on an accepted address phase
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q <= S_IDLE;
      lfsr_q <= SEED;
      ch_q <= '0;
      issued_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= state_q == S_DRAIN && empty;
      if (state_q == S_IDLE && start) begin
        ch_q <= '0;
        issued_q <= '0;
      end
      if (push) begin
        lfsr_q <= lfsr_next(lfsr_q);
        issued_q <= issued_q + 1;
        wdata_q <= ent.wdata;
      end
      if (state_q == S_DATA && hready_a) ch_q <= ch_nxt;
    end
  // saturating error and mismatch counters, cleared only by reset
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      mis_q <= '0;
      aerr_q <= '0;
      perr_q <= '0;
    end else begin
      mis_q <= mis_q + 16'(apb_fire && bad && mis_q != 16'hFFFF);
      aerr_q <= aerr_q + 16'(state_q == S_DATA && hready_a && HRESP[ch_q] && aerr_q != 16'hFFFF);
      perr_q <= perr_q + 16'(apb_fire && PSLVERR && perr_q != 16'hFFFF);
    end
endmodule

// File: tb/tb_ahb5_rand_txn_gen_chk.sv
// tb_ahb5_rand_txn_gen_chk: directed bridge-emulating bench with hand-derived LFSR transfers
module tb_ahb5_rand_txn_gen_chk;
  localparam int N = 2;
  logic HCLK = 1'b0, HRESETn = 1'b0, start = 1'b0;
  logic [N-1:0][31:0] HADDR, HWDATA, HRDATA;
  logic [N-1:0] HWRITE, HSEL, HMASTLOCK, HNONSEC, HREADY, HRESP;
  logic [N-1:0][2:0] HSIZE, HBURST;
  logic [N-1:0][3:0] HPROT, HCID;
  logic [N-1:0][1:0] HTRANS;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PREADY = 1'b1, PSLVERR = 1'b0;
  logic [3:0] PSTRB = '0;
  logic busy, done;
  logic [15:0] mismatch_cnt, ahb_err_cnt, apb_err_cnt;
  int errors = 0, checks = 0;

  always #5 HCLK = ~HCLK;

  ahb5_rand_txn_gen_chk #(.NUM_AHB(N), .SB_DEPTH(2), .NUM_TXN(4), .ADDR_BASE(32'h4000_0002)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HMASTLOCK(HMASTLOCK),
    .HNONSEC(HNONSEC), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HCID(HCID),
    .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PSTRB(PSTRB),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt), .ahb_err_cnt(ahb_err_cnt),
    .apb_err_cnt(apb_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ahb_xfer(input int ch, input logic [31:0] a, input logic w, input logic [2:0] s,
                          input logic [3:0] prot, input logic [3:0] cid, input logic ns,
                          input logic [31:0] d, input bit err);
    for (int n = 0; n < 50 && HTRANS[ch] !== 2'b10; n++) @(negedge HCLK);
    chk("htrans_nonseq", 32'(HTRANS[ch]), 32'h2);
    chk("hsel_onehot", 32'(HSEL), 32'(1 << ch));
    chk("haddr", HADDR[ch], a);
    chk("hwrite", 32'(HWRITE[ch]), 32'(w));
    chk("hsize", 32'(HSIZE[ch]), 32'(s));
    chk("hprot", 32'(HPROT[ch]), 32'(prot));
    chk("hcid", 32'(HCID[ch]), 32'(cid));
    chk("hnonsec", 32'(HNONSEC[ch]), 32'(ns));
    chk("hburst_lock", 32'({HBURST[ch], HMASTLOCK[ch]}), 32'h0);
    @(negedge HCLK);
    chk("htrans_data_idle", 32'(HTRANS), 32'h0);
    if (w) chk("hwdata", HWDATA[ch], d);
    if (err) begin
      HREADY[ch] = 1'b0;
      HRESP[ch] = 1'b1;
      @(negedge HCLK);
      chk("htrans_err_idle", 32'(HTRANS), 32'h0);
      HREADY[ch] = 1'b1;
      @(negedge HCLK);
      HRESP[ch] = 1'b0;
    end
  endtask

  task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] st,
                          input logic err, input int waits, output int nonseq);
    nonseq = 0;
    PSEL = 1'b1;
    PENABLE = 1'b0;
    PADDR = a;
    PWRITE = w;
    PWDATA = d;
    PSTRB = st;
    PSLVERR = 1'b0;
    PREADY = waits == 0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    for (int n = 0; n < waits; n++) begin
      @(negedge HCLK);
      if (HTRANS !== '0) nonseq++;
    end
    PREADY = 1'b1;
    PSLVERR = err;
    @(negedge HCLK);
    PSEL = 1'b0;
    PENABLE = 1'b0;
    PSLVERR = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 20 && done !== 1'b1; n++) @(negedge HCLK);
    chk("done", 32'(done), 32'h1);
    chk("busy_end", 32'(busy), 32'h0);
    @(negedge HCLK);
    chk("done_pulse", 32'(done), 32'h0);
  endtask

  initial begin
    int ns;
    HREADY = '1;
    HRESP = '0;
    HRDATA = '0;
    repeat (2) @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_hsel", 32'(HSEL), 32'h0);
    chk("rst_haddr", HADDR[0] | HADDR[1], 32'h0);
    chk("rst_hwdata", HWDATA[0] | HWDATA[1], 32'h0);
    chk("rst_busy_done", 32'({busy, done}), 32'h0);
    chk("rst_counters", {mismatch_cnt, ahb_err_cnt}, 32'h0);
    chk("rst_apb_err", 32'(apb_err_cnt), 32'h0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    chk("addr_after_start", 32'(HTRANS[0]), 32'h2);
    ahb_xfer(0, 32'h4000_0026, 1'b1, 3'd0, 4'd4, 4'd0, 1'b0, 32'h2404_8735, 1'b0);
    ahb_xfer(1, 32'h4000_0010, 1'b0, 3'd2, 4'd2, 4'd0, 1'b0, 32'h0, 1'b0);
    @(negedge HCLK);
    chk("busy_stall", 32'(busy), 32'h1);
    apb_xfer(32'h4000_0026, 1'b1, 32'h2404_8735, 4'b0100, 1'b0, 20, ns);
    chk("stall_no_nonseq", 32'(ns), 32'h0);
    chk("mis_strb_ok", 32'(mismatch_cnt), 32'h0);
    ahb_xfer(0, 32'h4000_080A, 1'b0, 3'd1, 4'd1, 4'd0, 1'b1, 32'h0, 1'b1);
    chk("ahb_err_cnt", 32'(ahb_err_cnt), 32'h1);
    apb_xfer(32'h4000_0000, 1'b0, 32'h0, 4'b0000, 1'b0, 0, ns);
    chk("mis_paddr_bit4", 32'(mismatch_cnt), 32'h1);
    ahb_xfer(1, 32'h4000_0404, 1'b1, 3'd2, 4'd0, 4'd8, 1'b0, 32'hE024_3DA9, 1'b0);
    apb_xfer(32'h4000_080A, 1'b0, 32'h0, 4'b0000, 1'b0, 0, ns);
    apb_xfer(32'h4000_0404, 1'b1, 32'hE024_3DA9, 4'b1111, 1'b1, 0, ns);
    wait_done();
    chk("run1_mismatch", 32'(mismatch_cnt), 32'h1);
    chk("run1_ahb_err", 32'(ahb_err_cnt), 32'h1);
    chk("run1_apb_err", 32'(apb_err_cnt), 32'h1);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    ahb_xfer(0, 32'h4000_0202, 1'b0, 3'd0, 4'd0, 4'd4, 1'b0, 32'h0, 1'b0);
    ahb_xfer(1, 32'h4000_0902, 1'b0, 3'd0, 4'd0, 4'd2, 1'b1, 32'h0, 1'b0);
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    chk("arst_htrans", 32'(HTRANS), 32'h0);
    chk("arst_hsel", 32'(HSEL), 32'h0);
    chk("arst_haddr", HADDR[0] | HADDR[1], 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_counters", {mismatch_cnt, ahb_err_cnt}, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    ahb_xfer(0, 32'h4000_0026, 1'b1, 3'd0, 4'd4, 4'd0, 1'b0, 32'h2404_8735, 1'b0);
    ahb_xfer(1, 32'h4000_0010, 1'b0, 3'd2, 4'd2, 4'd0, 1'b0, 32'h0, 1'b0);
    @(negedge HCLK);
    apb_xfer(32'h4000_0026, 1'b1, 32'h2404_8735, 4'b0001, 1'b0, 0, ns);
    chk("mis_strb_bad", 32'(mismatch_cnt), 32'h1);
    ahb_xfer(0, 32'h4000_080A, 1'b0, 3'd1, 4'd1, 4'd0, 1'b1, 32'h0, 1'b0);
    apb_xfer(32'h4000_0010, 1'b0, 32'h0, 4'b0000, 1'b0, 0, ns);
    ahb_xfer(1, 32'h4000_0404, 1'b1, 3'd2, 4'd0, 4'd8, 1'b0, 32'hE024_3DA9, 1'b0);
    apb_xfer(32'h4000_080A, 1'b0, 32'h0, 4'b0000, 1'b0, 0, ns);
    apb_xfer(32'h4000_0404, 1'b1, 32'hE024_3DA9, 4'b1111, 1'b0, 0, ns);
    wait_done();
    chk("run2_mismatch", 32'(mismatch_cnt), 32'h1);
    chk("run2_errs", {ahb_err_cnt, apb_err_cnt}, 32'h0);
    apb_xfer(32'h4000_0000, 1'b0, 32'h0, 4'b0000, 1'b0, 0, ns);
    chk("mis_empty_fifo", 32'(mismatch_cnt), 32'h2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
